// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the AHB command arbiter: burst encodings,
// beat-count decode and the arbiter FSM state type.
package ahb_arb_pkg;

  localparam int NREQ_DEF      = 2;
  localparam int OWN_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } burst_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } fsm_e;

  // Undefined-length INCR is arbitrated beat by beat, like a single.
  function automatic logic [4:0] burst_beats(input burst_e b);
    case (b)
      BURST_SINGLE, BURST_INCR:   burst_beats = 5'd1;
      BURST_WRAP4, BURST_INCR4:   burst_beats = 5'd4;
      BURST_WRAP8, BURST_INCR8:   burst_beats = 5'd8;
      BURST_WRAP16, BURST_INCR16: burst_beats = 5'd16;
      default:                    burst_beats = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_id_fifo.sv
// Small FIFO remembering which requester owns each outstanding read.
// DEPTH must be a power of two, at least 2.
module ahb_id_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_r [DEPTH];
  logic [AW:0]  wptr_r;
  logic [AW:0]  rptr_r;
  logic         push_s;
  logic         pop_s;

  // Extra pointer bit distinguishes full from empty.
  assign full   = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign empty  = (wptr_r == rptr_r);
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;
  assign dout   = mem_r[rptr_r[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (push_s) wptr_r <= wptr_r + (AW+1)'(1);
      if (pop_s)  rptr_r <= rptr_r + (AW+1)'(1);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ahb_cmd_arb.sv
// Round-robin arbiter of requester command beats onto one AHB master, with
// burst locking and in-order routing of read responses back to their owners.
module ahb_cmd_arb
  import ahb_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int OWN_DEPTH = OWN_DEPTH_DEF
) (
  input  logic                  hclk,
  input  logic                  hrst,
  input  logic [NREQ-1:0]       req_vld_i,
  input  logic [NREQ-1:0]       req_wr_en_i,
  input  logic [NREQ-1:0]       req_rd_en_i,
  input  logic [NREQ-1:0][2:0]  req_size_i,
  input  logic [NREQ-1:0][31:0] req_addr_i,
  input  logic [NREQ-1:0][31:0] req_wdata_i,
  input  logic [NREQ-1:0][2:0]  req_burst_i,
  output logic [NREQ-1:0]       req_rdy_o,
  output logic [NREQ-1:0]       req_dout_vld_o,
  output logic [NREQ-1:0][31:0] req_rdata_o,
  input  logic [NREQ-1:0]       req_dout_rdy_i,
  output logic                  din_vld_o,
  output logic                  wr_en_o,
  output logic                  rd_en_o,
  output logic [2:0]            data_size_o,
  output logic [31:0]           addr_o,
  output logic [31:0]           wdata_o,
  output logic [2:0]            burst_o,
  input  logic                  din_rdy_i,
  input  logic                  dout_vld_i,
  input  logic [31:0]           rdata_i,
  output logic                  dout_rdy_o,
  output logic                  err_o
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  fsm_e            state_r;
  logic [IDW-1:0]  rr_ptr_r;
  logic [IDW-1:0]  owner_r;
  logic [3:0]      remaining_r;
  logic            err_r;

  logic [IDW-1:0]  grant_s;
  logic [IDW-1:0]  idx_s;
  logic            found_s;
  logic            g_vld_s;
  logic            g_rd_s;
  logic            blocked_s;
  logic            accept_s;
  logic [4:0]      beats_s;
  logic [IDW-1:0]  rr_next_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic [IDW-1:0]  head_s;
  logic            push_s;
  logic            pop_s;

  // Grant selection: latched owner while locked, else first valid from rr_ptr.
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    idx_s   = '0;
    if (state_r == ST_LOCK) begin
      grant_s = owner_r;
      found_s = 1'b1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        idx_s = IDW'((int'(rr_ptr_r) + k) % NREQ);
        if (!found_s && req_vld_i[idx_s]) begin
          grant_s = idx_s;
          found_s = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  assign g_vld_s   = found_s && req_vld_i[grant_s];
  assign g_rd_s    = req_rd_en_i[grant_s];
  assign blocked_s = g_rd_s && fifo_full_s;
  assign accept_s  = din_vld_o && din_rdy_i;
  assign push_s    = accept_s && g_rd_s;
  assign beats_s   = burst_beats(burst_e'(req_burst_i[grant_s]));
  assign rr_next_s = (grant_s == IDW'(NREQ - 1)) ? '0 : grant_s + IDW'(1);

  assign din_vld_o   = !hrst && g_vld_s && !blocked_s;
  assign wr_en_o     = req_wr_en_i[grant_s];
  assign rd_en_o     = req_rd_en_i[grant_s];
  assign data_size_o = req_size_i[grant_s];
  assign addr_o      = req_addr_i[grant_s];
  assign wdata_o     = req_wdata_i[grant_s];
  assign burst_o     = req_burst_i[grant_s];

  // Ready goes only to the granted requester.
  always_comb begin
    req_rdy_o = '0;
    if (!hrst && found_s) begin
      req_rdy_o[grant_s] = din_rdy_i && !blocked_s;
    end else begin
      req_rdy_o = '0;
    end
  end

  // Response routing to the requester at the head of the owner FIFO.
  always_comb begin
    req_dout_vld_o = '0;
    if (!hrst && !fifo_empty_s) begin
      req_dout_vld_o[head_s] = dout_vld_i;
    end else begin
      req_dout_vld_o = '0;
    end
  end

  assign req_rdata_o = {NREQ{rdata_i}};
  assign dout_rdy_o  = fifo_empty_s ? 1'b1 : req_dout_rdy_i[head_s];
  assign pop_s       = dout_vld_i && dout_rdy_o && !fifo_empty_s;
  assign err_o       = err_r;

  ahb_id_fifo #(
    .W     (IDW),
    .DEPTH (OWN_DEPTH)
  ) u_owner_fifo (
    .clk   (hclk),
    .rst   (hrst),
    .push  (push_s),
    .din   (grant_s),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Arbiter FSM: burst lock, round-robin pointer and sticky response error.
  always_ff @(posedge hclk) begin
    if (hrst) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      owner_r     <= '0;
      remaining_r <= 4'd0;
      err_r       <= 1'b0;
    end else begin
      if (dout_vld_i && fifo_empty_s) err_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (beats_s > 5'd1) begin
              state_r     <= ST_LOCK;
              owner_r     <= grant_s;
              remaining_r <= 4'(beats_s - 5'd1);
            end else begin
              rr_ptr_r <= rr_next_s;
            end
          end
        end
        ST_LOCK: begin
          if (accept_s) begin
            remaining_r <= remaining_r - 4'd1;
            if (remaining_r == 4'd1) begin
              state_r  <= ST_IDLE;
              rr_ptr_r <= rr_next_s;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_cmd_arb.sv
// Directed bench for ahb_cmd_arb: arbitration, burst lock, backpressure,
// response routing, owner FIFO full, sticky error and mid-burst reset.
module tb_ahb_cmd_arb;
  import ahb_arb_pkg::*;

  logic             hclk = 1'b0;
  logic             hrst;
  logic [1:0]       req_vld, req_wr, req_rd, req_rdy, req_dout_vld, req_dout_rdy;
  logic [1:0][2:0]  req_size, req_burst;
  logic [1:0][31:0] req_addr, req_wdata, req_rdata;
  logic             din_vld, wr_en, rd_en, din_rdy, dout_vld, dout_rdy, err;
  logic [2:0]       data_size, burst;
  logic [31:0]      addr, wdata, rdata;
  int               vecs = 0;
  int               errs = 0;

  ahb_cmd_arb #(.NREQ(2), .OWN_DEPTH(4)) dut (
    .hclk(hclk), .hrst(hrst),
    .req_vld_i(req_vld), .req_wr_en_i(req_wr), .req_rd_en_i(req_rd),
    .req_size_i(req_size), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_burst_i(req_burst), .req_rdy_o(req_rdy),
    .req_dout_vld_o(req_dout_vld), .req_rdata_o(req_rdata), .req_dout_rdy_i(req_dout_rdy),
    .din_vld_o(din_vld), .wr_en_o(wr_en), .rd_en_o(rd_en), .data_size_o(data_size),
    .addr_o(addr), .wdata_o(wdata), .burst_o(burst), .din_rdy_i(din_rdy),
    .dout_vld_i(dout_vld), .rdata_i(rdata), .dout_rdy_o(dout_rdy), .err_o(err)
  );

  always #5 hclk = ~hclk;

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic clr();
    req_vld = 2'b00; req_wr = 2'b00; req_rd = 2'b00; req_size = '0; req_burst = '0;
    req_addr = '0; req_wdata = '0; din_rdy = 1'b1; dout_vld = 1'b0; rdata = 32'h0;
    req_dout_rdy = 2'b11;
  endtask

  task automatic test_reset();
    clr();
    hrst = 1'b1; req_vld = 2'b11; req_rd = 2'b11; dout_vld = 1'b1;
    cyc(); cyc(); #1;
    vecs++; if (din_vld !== 1'b0) begin errs++; $display("FAIL reset_din_vld got=%b exp=0", din_vld); end
    vecs++; if (req_rdy !== 2'b00) begin errs++; $display("FAIL reset_req_rdy got=%b exp=00", req_rdy); end
    vecs++; if (req_dout_vld !== 2'b00) begin errs++; $display("FAIL reset_dout_vld got=%b exp=00", req_dout_vld); end
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL reset_err got=%b exp=0", err); end
    clr(); hrst = 1'b0; #1;
    vecs++; if (dout_rdy !== 1'b1) begin errs++; $display("FAIL reset_sink_rdy got=%b exp=1", dout_rdy); end
    vecs++; if (dut.rr_ptr_r !== 1'b0 || dut.state_r !== ST_IDLE) begin errs++;
      $display("FAIL reset_state rr=%b st=%b exp rr=0 st=IDLE", dut.rr_ptr_r, dut.state_r); end
    cyc();
  endtask

  task automatic test_contention();
    req_vld = 2'b11; req_wr = 2'b11;
    req_addr[0] = 32'h10; req_addr[1] = 32'h20;
    req_size[0] = 3'd2; req_wdata[0] = 32'hDEAD_0000; req_wdata[1] = 32'hBEEF_0001;
    #1;
    vecs++; if (req_rdy !== 2'b01 || din_vld !== 1'b1 || addr !== 32'h10) begin errs++;
      $display("FAIL contention_c0 rdy=%b vld=%b addr=%h exp 01/1/10", req_rdy, din_vld, addr); end
    vecs++; if (wr_en !== 1'b1 || data_size !== 3'd2 || wdata !== 32'hDEAD_0000) begin errs++;
      $display("FAIL contention_mux wr=%b size=%0d wdata=%h exp 1/2/dead0000", wr_en, data_size, wdata); end
    cyc(); #1;
    vecs++; if (req_rdy !== 2'b10 || addr !== 32'h20 || wdata !== 32'hBEEF_0001) begin errs++;
      $display("FAIL contention_c1 rdy=%b addr=%h wdata=%h exp 10/20/beef0001", req_rdy, addr, wdata); end
    cyc(); clr(); #1;
    vecs++; if (dut.rr_ptr_r !== 1'b0) begin errs++; $display("FAIL contention_rr got=%b exp=0", dut.rr_ptr_r); end
  endtask

  task automatic test_burst_lock();
    req_vld = 2'b10; req_wr = 2'b10; req_burst[1] = 3'd3; req_addr[1] = 32'h1000; #1;
    vecs++; if (req_rdy !== 2'b10 || addr !== 32'h1000 || burst !== 3'd3) begin errs++;
      $display("FAIL lock_beat0 rdy=%b addr=%h burst=%0d exp 10/1000/3", req_rdy, addr, burst); end
    cyc();
    req_vld = 2'b11; req_wr = 2'b11; req_addr[0] = 32'h500; req_burst[1] = 3'd0;
    for (int i = 1; i < 4; i++) begin
      req_addr[1] = 32'h1000 + 32'(4 * i); #1;
      vecs++; if (req_rdy !== 2'b10 || addr !== 32'h1000 + 32'(4 * i)) begin errs++;
        $display("FAIL lock_beat%0d rdy=%b addr=%h exp 10/%h", i, req_rdy, addr, 32'h1000 + 32'(4 * i)); end
      cyc();
    end
    #1;
    vecs++; if (req_rdy !== 2'b01 || addr !== 32'h500) begin errs++;
      $display("FAIL lock_release rdy=%b addr=%h exp 01/500", req_rdy, addr); end
    cyc(); clr();
  endtask

  task automatic test_backpressure();
    int beat = 0;
    req_vld = 2'b01; req_wr = 2'b01; req_burst[0] = 3'd4;
    for (int c = 0; c < 20 && beat < 8; c++) begin
      req_addr[0] = 32'h2000 + 32'(4 * beat);
      din_rdy = (c < 3 || c > 5);
      #1;
      vecs++; if (din_vld !== 1'b1 || addr !== 32'h2000 + 32'(4 * beat)) begin errs++;
        $display("FAIL bp_beat%0d vld=%b addr=%h exp 1/%h", beat, din_vld, addr, 32'h2000 + 32'(4 * beat)); end
      if (c >= 3 && c <= 5) begin
        vecs++; if (dut.remaining_r !== 4'd5) begin errs++;
          $display("FAIL bp_remaining cyc=%0d got=%0d exp=5", c, dut.remaining_r); end
      end
      if (din_rdy) beat++;
      cyc();
    end
    vecs++; if (beat !== 8) begin errs++; $display("FAIL bp_beats got=%0d exp=8", beat); end
    vecs++; if (dut.state_r !== ST_IDLE || dut.rr_ptr_r !== 1'b1) begin errs++;
      $display("FAIL bp_end st=%b rr=%b exp IDLE/1", dut.state_r, dut.rr_ptr_r); end
    clr();
  endtask

  task automatic test_routing();
    req_vld = 2'b01; req_rd = 2'b01; req_addr[0] = 32'h100; #1;
    vecs++; if (req_rdy !== 2'b01 || rd_en !== 1'b1 || addr !== 32'h100) begin errs++;
      $display("FAIL route_rd0 rdy=%b rd=%b addr=%h exp 01/1/100", req_rdy, rd_en, addr); end
    cyc();
    req_vld = 2'b10; req_rd = 2'b10; req_addr[1] = 32'h200; #1;
    vecs++; if (req_rdy !== 2'b10 || addr !== 32'h200) begin errs++;
      $display("FAIL route_rd1 rdy=%b addr=%h exp 10/200", req_rdy, addr); end
    cyc(); clr();
    dout_vld = 1'b1; rdata = 32'hAAAA; req_dout_rdy = 2'b10; #1;
    vecs++; if (req_dout_vld !== 2'b01 || dout_rdy !== 1'b0 || req_rdata[0] !== 32'hAAAA) begin errs++;
      $display("FAIL route_stall vld=%b rdy=%b data=%h exp 01/0/aaaa", req_dout_vld, dout_rdy, req_rdata[0]); end
    cyc(); #1;
    vecs++; if (req_dout_vld !== 2'b01) begin errs++; $display("FAIL route_hold vld=%b exp=01", req_dout_vld); end
    req_dout_rdy = 2'b11; #1;
    vecs++; if (dout_rdy !== 1'b1) begin errs++; $display("FAIL route_rdy0 got=%b exp=1", dout_rdy); end
    cyc();
    rdata = 32'hBBBB; #1;
    vecs++; if (req_dout_vld !== 2'b10 || req_rdata[1] !== 32'hBBBB) begin errs++;
      $display("FAIL route_resp1 vld=%b data=%h exp 10/bbbb", req_dout_vld, req_rdata[1]); end
    cyc(); clr(); #1;
    vecs++; if (dout_rdy !== 1'b1 || err !== 1'b0) begin errs++;
      $display("FAIL route_drained rdy=%b err=%b exp 1/0", dout_rdy, err); end
  endtask

  task automatic test_fifo_full();
    req_vld = 2'b01; req_rd = 2'b01; req_addr[0] = 32'h300;
    for (int i = 0; i < 4; i++) begin
      #1;
      vecs++; if (req_rdy !== 2'b01) begin errs++; $display("FAIL full_rd%0d rdy=%b exp=01", i, req_rdy); end
      cyc();
    end
    #1;
    vecs++; if (req_rdy !== 2'b00 || din_vld !== 1'b0) begin errs++;
      $display("FAIL full_block rdy=%b vld=%b exp 00/0", req_rdy, din_vld); end
    req_vld = 2'b11; req_wr = 2'b10; req_addr[1] = 32'h400; #1;
    vecs++; if (req_rdy !== 2'b10 || din_vld !== 1'b1 || wr_en !== 1'b1 || rd_en !== 1'b0) begin errs++;
      $display("FAIL full_write rdy=%b vld=%b wr=%b rd=%b exp 10/1/1/0", req_rdy, din_vld, wr_en, rd_en); end
    cyc();
    req_vld = 2'b01; req_wr = 2'b00; #1;
    vecs++; if (req_rdy !== 2'b00) begin errs++; $display("FAIL full_still rdy=%b exp=00", req_rdy); end
    dout_vld = 1'b1; rdata = 32'h1; #1;
    vecs++; if (req_dout_vld !== 2'b01 || req_rdy !== 2'b00) begin errs++;
      $display("FAIL full_pop_cycle dvld=%b rdy=%b exp 01/00", req_dout_vld, req_rdy); end
    cyc();
    dout_vld = 1'b0; #1;
    vecs++; if (req_rdy !== 2'b01) begin errs++; $display("FAIL full_unblock rdy=%b exp=01", req_rdy); end
    cyc(); req_vld = 2'b00; req_rd = 2'b00;
    for (int i = 0; i < 4; i++) begin
      dout_vld = 1'b1; #1;
      vecs++; if (req_dout_vld !== 2'b01) begin errs++; $display("FAIL full_drain%0d vld=%b exp=01", i, req_dout_vld); end
      cyc();
    end
    clr(); #1;
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL full_err got=%b exp=0", err); end
  endtask

  task automatic test_err_reset();
    dout_vld = 1'b1; #1;
    vecs++; if (req_dout_vld !== 2'b00 || dout_rdy !== 1'b1) begin errs++;
      $display("FAIL err_sink vld=%b rdy=%b exp 00/1", req_dout_vld, dout_rdy); end
    cyc(); dout_vld = 1'b0; #1;
    vecs++; if (err !== 1'b1) begin errs++; $display("FAIL err_set got=%b exp=1", err); end
    cyc(); cyc(); #1;
    vecs++; if (err !== 1'b1) begin errs++; $display("FAIL err_sticky got=%b exp=1", err); end
    req_vld = 2'b01; req_rd = 2'b01; req_burst[0] = 3'd7; req_addr[0] = 32'h3000;
    cyc(); cyc(); #1;
    vecs++; if (dut.state_r !== ST_LOCK || dut.remaining_r !== 4'd14) begin errs++;
      $display("FAIL rst_mid_lock st=%b rem=%0d exp LOCK/14", dut.state_r, dut.remaining_r); end
    hrst = 1'b1; #1;
    vecs++; if (din_vld !== 1'b0 || req_rdy !== 2'b00) begin errs++;
      $display("FAIL rst_mid_outputs vld=%b rdy=%b exp 0/00", din_vld, req_rdy); end
    cyc(); hrst = 1'b0; clr(); req_dout_rdy = 2'b00; #1;
    vecs++; if (dut.state_r !== ST_IDLE || dut.remaining_r !== 4'd0 || err !== 1'b0) begin errs++;
      $display("FAIL rst_after st=%b rem=%0d err=%b exp IDLE/0/0", dut.state_r, dut.remaining_r, err); end
    vecs++; if (dout_rdy !== 1'b1) begin errs++; $display("FAIL rst_fifo_empty rdy=%b exp=1", dout_rdy); end
    cyc(); clr();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_contention();
    test_burst_lock();
    test_backpressure();
    test_routing();
    test_fifo_full();
    test_err_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ahb_cmd_arb.md
AHB_CMD_ARB -- requirements
Module: ahb_cmd_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 2, meaning the number of requesters (2..4).
REQ-002 The block SHALL have parameter OWN_DEPTH, default 4, meaning the read-owner FIFO depth (power of 2).
REQ-003 The block SHALL have port hclk  in  1  clock; the single clock; all logic on rising edge.
REQ-004 The block SHALL have port hrst  in  1  reset; synchronous, active-high.
REQ-005 The block SHALL have, per requester n, the following inputs: req_vld_i[n] (1), req_wr_en_i[n] (1), req_rd_en_i[n] (1), req_size_i[n] (3), req_addr_i[n] (32), req_wdata_i[n] (32), req_burst_i[n] (3); meaning a requester command beat.
REQ-006 The block SHALL have output req_rdy_o[n] (1), meaning the beat is accepted when req_vld_i[n]&&req_rdy_o[n].
REQ-007 The block SHALL have, per requester n, outputs req_dout_vld_o[n] (1) and req_rdata_o[n] (32), and input req_dout_rdy_i[n] (1); meaning the read response to requester n.
REQ-008 The block SHALL have downstream outputs din_vld_o (1), wr_en_o (1), rd_en_o (1), data_size_o (3), addr_o (32), wdata_o (32) and burst_o (3), and input din_rdy_i (1); meaning the command to the AHB master.
REQ-009 The block SHALL have downstream inputs dout_vld_i (1) and rdata_i (32), and output dout_rdy_o (1); meaning the read response from the AHB master.
REQ-010 The block SHALL have output err_o  out  1, a sticky flag for an unexpected response.

Function
REQ-011 The burst beat count SHALL be: 0 single=1; 1 incr=1; 2/3 wrap4/incr4=4; 4/5 wrap8/incr8=8; 6/7 wrap16/incr16=16.
REQ-012 The FSM SHALL have two states: IDLE and LOCK.
REQ-013 In IDLE, the grant SHALL go to the first requester with req_vld_i asserted, searching round-robin from rr_ptr; the grant decision is combinational, so there is zero added latency.
REQ-014 The downstream command SHALL be a combinational mux of the granted requester; din_vld_o SHALL equal granted vld && !blocked; req_rdy_o[g] SHALL equal din_rdy_i && !blocked; every non-granted requester SHALL see rdy=0.
REQ-015 "blocked" SHALL mean that the granted beat has rd_en=1 and the owner FIFO is full; write beats are never blocked.
REQ-016 When the first beat is accepted in IDLE with count>1, the FSM SHALL go to LOCK, latch the owner, and set remaining=count-1.
REQ-017 In LOCK, only the latched owner SHALL be muxed; each accepted beat SHALL decrement remaining; on the beat that brings remaining to 0, the FSM SHALL return to IDLE.
REQ-018 At burst end (a single beat accepted in IDLE, or the last LOCK beat), rr_ptr SHALL become owner+1 mod NREQ.
REQ-019 In LOCK, the burst_i of later beats SHALL be ignored for the count; the latched count governs.
REQ-020 Each accepted read beat SHALL push the owner id into the owner FIFO.
REQ-021 Response routing: while the FIFO is non-empty with head h, req_dout_vld_o[h] SHALL equal dout_vld_i, all other requesters SHALL see req_dout_vld_o=0, req_rdata_o[*] SHALL equal rdata_i, and dout_rdy_o SHALL equal req_dout_rdy_i[h].
REQ-022 The FIFO SHALL pop on dout_vld_i&&dout_rdy_o.
REQ-023 On a simultaneous push and pop, the occupancy SHALL be unchanged; a full FIFO SHALL block a push even if a pop occurs in the same cycle.
REQ-024 With the FIFO empty: dout_rdy_o SHALL be 1 (sink); dout_vld_i=1 SHALL set err_o; no requester response SHALL be raised.
REQ-025 Write beats SHALL produce no response entry.

Reset
REQ-026 With hrst=1, the block SHALL set state=IDLE, rr_ptr=0, remaining=0, FIFO empty (pointers 0), and err_o=0.
REQ-027 During reset, din_vld_o, all req_rdy_o and all req_dout_vld_o SHALL be 0.
REQ-028 A reset in the middle of a burst SHALL abandon the burst; outstanding read owners are dropped.

Structure
REQ-029 Shared package ahb_arb_pkg SHALL hold: the burst_e enum (8 encodings), the function burst_beats(burst_e), the fsm state enum, and the NREQ and OWN_DEPTH defaults.
REQ-030 The owner FIFO SHALL be a sub-module ahb_id_fifo, parameterized by width $clog2(NREQ) and depth OWN_DEPTH.

Verification
REQ-031 Scenario contention: req0 and req1 both issue a single write at the same cycle, rr_ptr=0 -> req0 is granted in cycle 0, then req1 in cycle 1, and rr_ptr ends at 0.
REQ-032 Scenario burst lock: req1 issues incr4 writes while req0 holds vld -> exactly 4 req1 beats pass downstream before req0 is granted; no interleaving occurs.
REQ-033 Scenario backpressure: din_rdy_i=0 for 3 cycles mid-wrap8 -> remaining holds; all 8 beats are delivered in order, and the FSM returns to IDLE after the 8th beat.
REQ-034 Scenario routing: req0 reads 0x100, then req1 reads 0x200, with responses 0xAAAA then 0xBBBB -> req0 gets 0xAAAA and req1 gets 0xBBBB; req_dout_rdy_i[0]=0 stalls dout_rdy_o.
REQ-035 Scenario FIFO full: 5 single reads with no responses, OWN_DEPTH=4 -> the 5th read is held (rdy=0) until the first response pops; a write issued in the meantime still passes.
REQ-036 Scenario errors and reset: dout_vld_i pulsed with the FIFO empty -> err_o=1 sticky; hrst asserted at beat 2 of incr16 -> the next cycle is IDLE with the FIFO empty and err_o=0.
